router_out_port_drain: RTL and testbench
========================================

Name: router_out_port_drain

Overview:
Output-port read side of the 8x8 router. Drains the eight per-input FIFOs that hold traffic for one output port: picks a non-empty FIFO round-robin, pops one whole packet from it, and presents each word on a valid/ready output link. Holds the grant for the full packet so packets never interleave. One instance per router output port; sits between the input FIFOs and the output link serializer.

Parameters:
NUM_IN, 8, number of source FIFOs (power of two)
DATA_W, 32, word width
SEL_W, 3, log2(NUM_IN)

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
fifo_empty  input  NUM_IN  per-FIFO empty flag
fifo_rd_en  output  NUM_IN  per-FIFO pop request, one-hot or zero
fifo_rd_data  input  NUM_IN*DATA_W  FIFO data; slice i = bits [i*DATA_W +: DATA_W]
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts the word this cycle
out_data  output  DATA_W  packet word
out_sop  output  1  word is a packet header
out_eop  output  1  word is the last word of the packet
out_src  output  SEL_W  source FIFO index of the current word

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE, rr_ptr=0, remaining=0, fifo_rd_en=0, out_valid=0, out_data=0, out_sop=0, out_eop=0, out_src=0. Reset mid-packet abandons the packet; no pop is issued after reset.
- Packet format: header word bits [27:24] = payload length L (0..15); packet = header + L words. Header with L=0 gives sop=eop=1.
- FIFO read contract: slice i is valid in the cycle after fifo_rd_en[i] was high, and is held until the next pop. At most one fifo_rd_en bit high per cycle, only when that FIFO is not empty. No more than one outstanding pop.
- States:
  - IDLE: if any fifo_empty bit is 0, grant the first non-empty index scanning rr_ptr, rr_ptr+1, ... mod NUM_IN; go to POP. Otherwise stay.
  - POP: fifo_rd_en[grant]=1 for exactly one cycle; go to CAPT.
  - CAPT: register fifo_rd_data[grant] into out_data, set out_valid=1, out_src=grant. On the first word: sop=1, load remaining=L; eop=(L==0). On later words: sop=0, eop=(remaining==1). Go to SEND.
  - SEND: hold all out_* stable while out_ready=0. When out_valid and out_ready are both 1: out_valid<=0, decrement remaining for non-header words. Then:
    - if eop: rr_ptr<=grant+1 (wraps 7->0); go to IDLE.
    - else if fifo_empty[grant]=0: go to POP.
    - else: go to STALL.
  - STALL: wait on the same grant, with no other FIFO served, until fifo_empty[grant]=0; then go to POP.
- Throughput: at most one word per 3 cycles (POP, CAPT, SEND with out_ready=1). Latency from non-empty FIFO in IDLE to out_valid: 3 cycles.
- remaining is 4 bits and never underflows. A header is never counted as payload.
- fifo_empty changes on other ports during a packet are ignored until IDLE.
- out_ready asserted while out_valid=0 is ignored.

Decomposition:
- Shared package router_pkg: LEN_MSB=27, LEN_LSB=24, DATA_W, NUM_IN, SEL_W, state encoding (IDLE, POP, CAPT, SEND, STALL).
- Sub-module rr_pick: combinational round-robin priority select. Inputs request vector and rr_ptr; outputs grant index and any_req.

Test Plan:
- Single packet: FIFO 2 holds header 0x0300_00AA, then 0x11, 0x22, 0x33; out_ready=1 -> four words from src=2, sop on 0x0300_00AA, eop on 0x33; exactly 4 fifo_rd_en[2] pulses; rr_ptr=3 at the end.
- Round-robin wrap: FIFOs 0, 5 and 7 each hold one L=0 header; rr_ptr=6 -> service order 7, 0, 5.
- Back-pressure: L=2 packet from FIFO 4; out_ready=0 for 5 cycles on the second word -> out_data, sop, eop and src stay stable; no fifo_rd_en during the hold; the word is sent once when out_ready=1.
- Mid-packet underflow: FIFO 1 header L=3 with only 2 payload words present; FIFO 6 non-empty -> STALL on FIFO 1 and FIFO 6 is not served; pushing the third payload word completes the packet, then FIFO 6 is served.
- Reset mid-packet: assert reset_n=0 during SEND of word 2 of an L=4 packet -> all outputs return to reset values immediately; after release, first output is a new sop from the lowest non-empty index >= 0.
- One-hot check: random traffic on all 8 FIFOs for 2000 cycles -> fifo_rd_en never multi-hot, never asserted on an empty FIFO; no packet interleaving on out_src between sop and eop.

Source files
------------

// File: rtl/router_out_port_drain_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the router output-port drain logic: link and FIFO
// geometry, where the payload length lives in a header word, the drain FSM
// state encoding, and small helpers used by the drain and its arbiter.
// -----------------------------------------------------------------------------
package router_pkg;

    // Number of source FIFOs feeding one output port (power of two).
    localparam int NUM_IN = 8;
    // Packet word width.
    localparam int DATA_W = 32;
    // Width of a source index, log2(NUM_IN).
    localparam int SEL_W  = 3;

    // Payload length field inside a header word.
    localparam int LEN_MSB = 27;
    localparam int LEN_LSB = 24;
    localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

    // Drain FSM states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        CAPT  = 3'd2,
        SEND  = 3'd3,
        STALL = 3'd4
    } drain_state_t;

    // Payload length carried by a header word.
    function automatic logic [LEN_W-1:0] pkt_len(input logic [DATA_W-1:0] hdr);
        pkt_len = hdr[LEN_MSB:LEN_LSB];
    endfunction

    // Source index to a one-hot FIFO pop vector.
    function automatic logic [NUM_IN-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        sel_to_onehot      = '0;
        sel_to_onehot[sel] = 1'b1;
    endfunction

endpackage

// File: rtl/router_out_port_drain_if.sv
// -----------------------------------------------------------------------------
// router_out_port_drain_if
// Bundles the FIFO read side and the output link of one router output port.
//
//   fifo_empty    per-FIFO empty flag                       (FIFOs -> drain)
//   fifo_rd_en    per-FIFO pop request, one-hot or zero     (drain -> FIFOs)
//   fifo_rd_data  all FIFO heads, slice i = [i*DATA_W +: DATA_W]
//   out_valid     out_data carries a word                   (drain -> link)
//   out_ready     link accepts the word this cycle          (link -> drain)
//   out_data      packet word
//   out_sop       word is a packet header
//   out_eop       word is the last word of its packet
//   out_src       source FIFO index of the current word
//
// Modports: master = the drain, slave = the FIFOs plus downstream link.
// -----------------------------------------------------------------------------
interface router_out_port_drain_if;
    import router_pkg::*;

    logic [NUM_IN-1:0]        fifo_empty;
    logic [NUM_IN-1:0]        fifo_rd_en;
    logic [NUM_IN*DATA_W-1:0] fifo_rd_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_sop;
    logic                     out_eop;
    logic [SEL_W-1:0]         out_src;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  out_ready,
        output fifo_rd_en,
        output out_valid,
        output out_data,
        output out_sop,
        output out_eop,
        output out_src
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output out_ready,
        input  fifo_rd_en,
        input  out_valid,
        input  out_data,
        input  out_sop,
        input  out_eop,
        input  out_src
    );

endinterface

// File: rtl/router_out_port_drain_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority select. Scans req starting at rr_ptr and
// wrapping modulo N, and reports the first requesting index.
//
//   req      request vector, one bit per source
//   rr_ptr   index with the highest priority this cycle
//   grant    first requesting index at or after rr_ptr
//   any_req  at least one request bit is set (grant is meaningless otherwise)
// -----------------------------------------------------------------------------
module rr_pick
    import router_pkg::*;
#(
    parameter int N = NUM_IN,
    parameter int W = SEL_W
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic [W-1:0] grant,
    output logic         any_req
);

    logic [W-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest requester is
    // the last one written and wins. Index arithmetic wraps because N is a
    // power of two.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = rr_ptr + W'(i);
            if (req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/router_out_port_drain.sv
// -----------------------------------------------------------------------------
// router_out_port_drain
// Read side of one router output port. Picks a non-empty source FIFO
// round-robin, pops one whole packet from it word by word and presents each
// word on a valid/ready link. The grant is held for the whole packet, so
// packets from different sources never interleave; if the granted FIFO runs
// dry mid-packet the drain waits on it rather than serving anyone else.
//
//   clock    rising-edge clock
//   reset_n  asynchronous, active-low reset
//   bus      router_out_port_drain_if.master: FIFO flags/data/pops and the
//            output link (valid, ready, data, sop, eop, src)
//
// Packet format: header bits [27:24] hold the payload length L (0..15); the
// packet is the header followed by L words. Each word takes POP, CAPT and at
// least one SEND cycle.
// -----------------------------------------------------------------------------
module router_out_port_drain
    import router_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    router_out_port_drain_if.master bus
);

    drain_state_t      state_q,     state_d;
    logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;
    logic [SEL_W-1:0]  grant_q,     grant_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              first_q,     first_d;
    logic [NUM_IN-1:0] fifo_rd_en_q, fifo_rd_en_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_sop_q,   out_sop_d;
    logic              out_eop_q,   out_eop_d;
    logic [SEL_W-1:0]  out_src_q,   out_src_d;

    logic [NUM_IN-1:0] fifo_req;
    logic [SEL_W-1:0]  pick_grant;
    logic              pick_any;
    logic [DATA_W-1:0] rd_words [NUM_IN];
    logic [DATA_W-1:0] cur_word;
    logic [LEN_W-1:0]  cur_len;

    assign fifo_req = ~bus.fifo_empty;

    rr_pick #(
        .N (NUM_IN),
        .W (SEL_W)
    ) u_rr_pick (
        .req     (fifo_req),
        .rr_ptr  (rr_ptr_q),
        .grant   (pick_grant),
        .any_req (pick_any)
    );

    // Split the flat FIFO data bus into per-source words.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            rd_words[i] = bus.fifo_rd_data[i*DATA_W +: DATA_W];
        end
    end

    assign cur_word = rd_words[grant_q];
    assign cur_len  = pkt_len(cur_word);

    // Next-state logic. The pop strobe is computed on the transition into POP
    // so that it is a registered output that is high for exactly the POP cycle.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        remaining_d  = remaining_q;
        first_d      = first_q;
        fifo_rd_en_d = '0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sop_d    = out_sop_q;
        out_eop_d    = out_eop_q;
        out_src_d    = out_src_q;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d      = pick_grant;
                    first_d      = 1'b1;
                    fifo_rd_en_d = sel_to_onehot(pick_grant);
                    state_d      = POP;
                end
            end

            POP: begin
                state_d = CAPT;
            end

            CAPT: begin
                out_data_d  = cur_word;
                out_valid_d = 1'b1;
                out_src_d   = grant_q;
                if (first_q) begin
                    out_sop_d   = 1'b1;
                    out_eop_d   = (cur_len == '0);
                    remaining_d = cur_len;
                    first_d     = 1'b0;
                end else begin
                    out_sop_d = 1'b0;
                    out_eop_d = (remaining_q == LEN_W'(1));
                end
                state_d = SEND;
            end

            SEND: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    // Headers are not payload; the guard also keeps the
                    // counter from wrapping below zero.
                    if (!out_sop_q && (remaining_q != '0)) begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                    if (out_eop_q) begin
                        rr_ptr_d = grant_q + SEL_W'(1);
                        state_d  = IDLE;
                    end else if (!bus.fifo_empty[grant_q]) begin
                        fifo_rd_en_d = sel_to_onehot(grant_q);
                        state_d      = POP;
                    end else begin
                        state_d = STALL;
                    end
                end
            end

            STALL: begin
                // Mid-packet underflow: only the granted FIFO may resume.
                if (!bus.fifo_empty[grant_q]) begin
                    fifo_rd_en_d = sel_to_onehot(grant_q);
                    state_d      = POP;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any packet in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            remaining_q  <= '0;
            first_q      <= 1'b0;
            fifo_rd_en_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sop_q    <= 1'b0;
            out_eop_q    <= 1'b0;
            out_src_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            remaining_q  <= remaining_d;
            first_q      <= first_d;
            fifo_rd_en_q <= fifo_rd_en_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sop_q    <= out_sop_d;
            out_eop_q    <= out_eop_d;
            out_src_q    <= out_src_d;
        end
    end

    assign bus.fifo_rd_en = fifo_rd_en_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sop    = out_sop_q;
    assign bus.out_eop    = out_eop_q;
    assign bus.out_src    = out_src_q;

endmodule

// File: tb/tb_router_out_port_drain.sv
// -----------------------------------------------------------------------------
// tb_router_out_port_drain
// Self-checking bench for router_out_port_drain. A behavioural model of the
// eight source FIFOs answers pops; every word pushed into a FIFO is also
// pushed as an expected output into that source's scoreboard queue, and a
// monitor compares each presented output word against it. Directed tests also
// queue the expected order of packet headers.
// -----------------------------------------------------------------------------
module tb_router_out_port_drain;
    import router_pkg::*;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              sop;
        logic              eop;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    router_out_port_drain_if bus ();

    router_out_port_drain dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [DATA_W-1:0] fifo_q [NUM_IN][$];
    exp_t              exp_q  [NUM_IN][$];
    int                exp_order[$];
    bit                check_order = 1'b1;
    int                pops [NUM_IN];
    int                hs_count = 0;
    int                n_checks = 0;
    int                n_pass   = 0;
    bit                in_pkt   = 1'b0;
    int                pkt_src  = 0;
    int                mon_src;
    exp_t              mon_e;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Push one word into a source FIFO and the matching expected output.
    task automatic applyStimulus(input int src, input logic [DATA_W-1:0] word,
                                 input bit sop, input bit eop);
        exp_t e;
        e.data = word;
        e.sop  = sop;
        e.eop  = eop;
        fifo_q[src].push_back(word);
        exp_q[src].push_back(e);
    endtask

    // Push the first n_words words of a packet with payload length len.
    task automatic sendPacket(input int src, input int len, input logic [15:0] tag,
                              input int n_words);
        logic [DATA_W-1:0] hdr;
        hdr = {4'h0, 4'(len), 8'h00, tag};
        applyStimulus(src, hdr, 1'b1, len == 0);
        for (int k = 1; k < n_words; k++) begin
            applyStimulus(src, {tag, 16'(k)}, 1'b0, k == len);
        end
    endtask

    function automatic int totalPops();
        int t = 0;
        for (int i = 0; i < NUM_IN; i++) t += pops[i];
        return t;
    endfunction

    function automatic int pendingWords();
        int t = 0;
        for (int i = 0; i < NUM_IN; i++) t += exp_q[i].size();
        return t;
    endfunction

    task automatic waitHandshakes(input string name, input int target, input int budget);
        int n = 0;
        while (hs_count < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, hs_count, target);
    endtask

    task automatic waitValid(input string name, input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, bus.out_valid, 1);
    endtask

    // FIFO model: pops on the negedge inside the POP cycle, so the head is
    // ready during CAPT, then refreshes the empty flags for the next edge.
    initial begin
        bus.fifo_empty   = '1;
        bus.fifo_rd_data = '0;
        for (int i = 0; i < NUM_IN; i++) pops[i] = 0;
        forever begin
            @(negedge clock);
            if (bus.fifo_rd_en != '0) begin
                checkOutput("rd_en_onehot", $countones(bus.fifo_rd_en), 1);
                for (int i = 0; i < NUM_IN; i++) begin
                    if (bus.fifo_rd_en[i]) begin
                        checkOutput($sformatf("rd_en_nonempty%0d", i),
                                    fifo_q[i].size() != 0, 1);
                        if (fifo_q[i].size() != 0) begin
                            bus.fifo_rd_data[i*DATA_W +: DATA_W] = fifo_q[i].pop_front();
                        end
                        pops[i]++;
                    end
                end
            end
            for (int i = 0; i < NUM_IN; i++) begin
                bus.fifo_empty[i] = (fifo_q[i].size() == 0);
            end
        end
    end

    // Monitor: every presented word is compared with the head of its source's
    // queue, repeatedly while it is held, and popped on the handshake.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                in_pkt = 1'b0;
            end else if (bus.out_valid) begin
                mon_src = int'(bus.out_src);
                checkOutput("rd_en_while_valid", bus.fifo_rd_en, 0);
                if (exp_q[mon_src].size() == 0) begin
                    checkOutput($sformatf("pending_word_src%0d", mon_src),
                                exp_q[mon_src].size() != 0, 1);
                end else begin
                    mon_e = exp_q[mon_src][0];
                    checkOutput($sformatf("word_src%0d", mon_src),
                                {bus.out_data, bus.out_sop, bus.out_eop},
                                {mon_e.data, mon_e.sop, mon_e.eop});
                    if (bus.out_ready) begin
                        void'(exp_q[mon_src].pop_front());
                        hs_count++;
                        if (in_pkt) checkOutput("no_interleave", mon_src, pkt_src);
                        if (bus.out_sop) begin
                            in_pkt  = 1'b1;
                            pkt_src = mon_src;
                            if (check_order) begin
                                checkOutput("order_pending", exp_order.size() != 0, 1);
                                if (exp_order.size() != 0) begin
                                    checkOutput("service_order", mon_src, exp_order.pop_front());
                                end
                            end
                        end
                        if (bus.out_eop) in_pkt = 1'b0;
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends on its own.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time exceeded, got %0d handshakes", hs_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hs0;
        int base;
        int base6;
        int n;

        reset_n       = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) tick();

        // Reset state.
        checkOutput("reset_outputs", {bus.fifo_rd_en, bus.out_valid, bus.out_data,
                                      bus.out_sop, bus.out_eop, bus.out_src}, 0);
        checkOutput("reset_state", dut.state_q, IDLE);
        checkOutput("reset_rr_ptr", dut.rr_ptr_q, 0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Single L=3 packet from FIFO 2.
        hs0  = hs_count;
        base = pops[2];
        exp_order.push_back(2);
        applyStimulus(2, 32'h0300_00AA, 1'b1, 1'b0);
        applyStimulus(2, 32'h0000_0011, 1'b0, 1'b0);
        applyStimulus(2, 32'h0000_0022, 1'b0, 1'b0);
        applyStimulus(2, 32'h0000_0033, 1'b0, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("t1_latency", n, 3);
        waitHandshakes("t1_words", hs0 + 4, 60);
        repeat (2) tick();
        checkOutput("t1_pops", pops[2] - base, 4);
        checkOutput("t1_rr_ptr", dut.rr_ptr_q, 3);

        // Back-pressure on the second word of an L=2 packet from FIFO 4.
        hs0  = hs_count;
        base = pops[4];
        exp_order.push_back(4);
        applyStimulus(4, 32'h0200_0044, 1'b1, 1'b0);
        applyStimulus(4, 32'h0000_4401, 1'b0, 1'b0);
        applyStimulus(4, 32'h0000_4402, 1'b0, 1'b1);
        waitHandshakes("t2_header", hs0 + 1, 40);
        bus.out_ready = 1'b0;
        waitValid("t2_second_valid", 20);
        n = pops[4];
        repeat (5) tick();
        checkOutput("t2_no_pop_hold", pops[4] - n, 0);
        checkOutput("t2_no_send_hold", hs_count, hs0 + 1);
        checkOutput("t2_still_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        waitHandshakes("t2_words", hs0 + 3, 40);
        checkOutput("t2_pops", pops[4] - base, 3);

        // Header-only packet from FIFO 5 moves the pointer to 6.
        hs0 = hs_count;
        exp_order.push_back(5);
        sendPacket(5, 0, 16'h0055, 1);
        waitHandshakes("t3_words", hs0 + 1, 40);
        checkOutput("t3_rr_ptr", dut.rr_ptr_q, 6);

        // Round-robin wrap from pointer 6: expect 7, 0, 5.
        hs0 = hs_count;
        exp_order.push_back(7);
        exp_order.push_back(0);
        exp_order.push_back(5);
        sendPacket(0, 0, 16'h00A0, 1);
        sendPacket(5, 0, 16'h00A5, 1);
        sendPacket(7, 0, 16'h00A7, 1);
        waitHandshakes("t4_words", hs0 + 3, 60);
        checkOutput("t4_rr_ptr", dut.rr_ptr_q, 6);

        // Mid-packet underflow on FIFO 1 while FIFO 6 waits.
        hs0   = hs_count;
        base6 = pops[6];
        exp_order.push_back(1);
        exp_order.push_back(6);
        sendPacket(1, 3, 16'h0011, 3);
        waitHandshakes("t5_partial", hs0 + 3, 60);
        repeat (4) tick();
        sendPacket(6, 0, 16'h0066, 1);
        repeat (10) tick();
        checkOutput("t5_stall_state", dut.state_q, STALL);
        checkOutput("t5_fifo6_untouched", pops[6] - base6, 0);
        checkOutput("t5_no_output", hs_count, hs0 + 3);
        applyStimulus(1, {16'h0011, 16'd3}, 1'b0, 1'b1);
        waitHandshakes("t5_words", hs0 + 5, 60);
        checkOutput("t5_fifo6_served", pops[6] - base6, 1);

        // Reset while word 2 of an L=4 packet from FIFO 3 is held.
        hs0 = hs_count;
        exp_order.push_back(3);
        sendPacket(3, 4, 16'h0033, 5);
        waitHandshakes("t6_header", hs0 + 1, 40);
        bus.out_ready = 1'b0;
        waitValid("t6_word2_valid", 20);
        base    = totalPops();
        reset_n = 1'b0;
        #1;
        checkOutput("t6_reset_outputs", {bus.fifo_rd_en, bus.out_valid, bus.out_data,
                                         bus.out_sop, bus.out_eop, bus.out_src}, 0);
        checkOutput("t6_reset_rr_ptr", dut.rr_ptr_q, 0);
        checkOutput("t6_reset_remaining", dut.remaining_q, 0);
        fifo_q[3].delete();
        exp_q[3].delete();
        exp_order.delete();
        repeat (2) tick();
        checkOutput("t6_no_pop_in_reset", totalPops() - base, 0);
        exp_order.push_back(2);
        exp_order.push_back(7);
        sendPacket(7, 0, 16'h0077, 1);
        sendPacket(2, 0, 16'h0022, 1);
        bus.out_ready = 1'b1;
        reset_n       = 1'b1;
        hs0           = hs_count;
        waitHandshakes("t6_after_reset", hs0 + 2, 60);

        // Random traffic on all FIFOs with random back-pressure.
        check_order = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            tick();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 13) == 0) begin
                int s;
                int l;
                s = int'($urandom_range(0, NUM_IN - 1));
                l = int'($urandom_range(0, 4));
                sendPacket(s, l, 16'(c), l + 1);
            end
        end
        bus.out_ready = 1'b1;
        n = 0;
        while (pendingWords() != 0 && n < 4000) begin
            tick();
            n++;
        end
        checkOutput("t7_drained", pendingWords(), 0);
        repeat (3) tick();
        checkOutput("t7_idle", dut.state_q, IDLE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
